// File: rtl/wb_dest_pipe.sv
// wb_dest_pipe: carries rd/RegWrite from EX/MEM to MEM/WB for forwarding, holds EX/MEM across a req/ack memory access.
// Optional saturating stall counter on stall_cnt_o is built when WB_DEST_PIPE_STALL_CNT_EN is defined.
module wb_dest_pipe #(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] IdEx_rd_i,
    input  logic              IdEx_Wb_i,
    input  logic              IdEx_MemRead_i,
    input  logic              IdEx_MemWrite_i,
    input  logic [REG_AW-1:0] IfId_rs_i,
    input  logic [REG_AW-1:0] IfId_rt_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic [REG_AW-1:0] ExMem_rd_o,
    output logic              ExMem_Wb_o,
    output logic              ExMem_MemRead_o,
    output logic [REG_AW-1:0] MemWb_rd_o,
    output logic              MemWb_Wb_o,
    output logic              load_use_stall_o,
    output logic              mem_stall_o
`ifdef WB_DEST_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } stateT;

    stateT             state;
    logic [REG_AW-1:0] exMemRd;
    logic              exMemWb;
    logic              exMemMemRead;
    logic [REG_AW-1:0] memWbRd;
    logic              memWbWb;
    logic              memStall;
    logic              loadUse;
    logic              incomingMemOp;

    assign mem_req_o       = (state == WAIT);
    assign memStall        = (state == WAIT) && !mem_ack_i;
    assign mem_stall_o     = memStall;
    assign incomingMemOp   = IdEx_MemRead_i || IdEx_MemWrite_i;

    // Gated by reset so every output reads 0 while the pipe is held in reset.
    assign loadUse = rst_n_i && IdEx_MemRead_i && (IdEx_rd_i != '0) &&
                     ((IdEx_rd_i == IfId_rs_i) || (IdEx_rd_i == IfId_rt_i));
    assign load_use_stall_o = loadUse;

    assign ExMem_rd_o      = exMemRd;
    assign ExMem_Wb_o      = exMemWb;
    assign ExMem_MemRead_o = exMemMemRead;
    assign MemWb_rd_o      = memWbRd;
    assign MemWb_Wb_o      = memWbWb;

    // While frozen, MEM/WB takes a bubble so the held op writes back exactly once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            exMemRd      <= '0;
            exMemWb      <= 1'b0;
            exMemMemRead <= 1'b0;
            memWbRd      <= '0;
            memWbWb      <= 1'b0;
        end else if (memStall) begin
            memWbRd <= '0;
            memWbWb <= 1'b0;
        end else begin
            memWbRd      <= exMemRd;
            memWbWb      <= exMemWb;
            exMemRd      <= IdEx_rd_i;
            exMemWb      <= IdEx_Wb_i;
            exMemMemRead <= IdEx_MemRead_i;
            state        <= incomingMemOp ? WAIT : IDLE;
        end
    end

`ifdef WB_DEST_PIPE_STALL_CNT_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stallCnt <= 16'h0000;
        end else if ((memStall || loadUse) && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'h0001;
        end
    end

    assign stall_cnt_o = stallCnt;
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Self-checking bench for wb_dest_pipe: reference model feeds an expected-output queue checked after each edge.
// Counter checks are compiled in only when WB_DEST_PIPE_STALL_CNT_EN is defined.
module tb_wb_dest_pipe;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [4:0] idExRd = '0;
    logic       idExWb = 1'b0;
    logic       idExMr = 1'b0;
    logic       idExMw = 1'b0;
    logic [4:0] ifIdRs = '0;
    logic [4:0] ifIdRt = '0;
    logic       memAck = 1'b0;
    logic       memReq;
    logic [4:0] exMemRd;
    logic       exMemWb;
    logic       exMemMr;
    logic [4:0] memWbRd;
    logic       memWbWb;
    logic       loadUse;
    logic       memStall;
`ifdef WB_DEST_PIPE_STALL_CNT_EN
    logic [15:0] stallCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state and the expected-output scoreboard.
    logic [4:0]  mExRd;
    logic        mExWb;
    logic        mExMr;
    logic [4:0]  mWbRd;
    logic        mWbWb;
    logic        mState;
    logic [13:0] expQ[$];
    logic [13:0] expVal;

    wb_dest_pipe #(.REG_AW(5)) dut (
        .clk_i            (clk),
        .rst_n_i          (rstN),
        .IdEx_rd_i        (idExRd),
        .IdEx_Wb_i        (idExWb),
        .IdEx_MemRead_i   (idExMr),
        .IdEx_MemWrite_i  (idExMw),
        .IfId_rs_i        (ifIdRs),
        .IfId_rt_i        (ifIdRt),
        .mem_ack_i        (memAck),
        .mem_req_o        (memReq),
        .ExMem_rd_o       (exMemRd),
        .ExMem_Wb_o       (exMemWb),
        .ExMem_MemRead_o  (exMemMr),
        .MemWb_rd_o       (memWbRd),
        .MemWb_Wb_o       (memWbWb),
        .load_use_stall_o (loadUse),
        .mem_stall_o      (memStall)
`ifdef WB_DEST_PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o      (stallCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obsVec();
        return {exMemRd, exMemWb, exMemMr, memWbRd, memWbWb, memReq};
    endfunction

    task automatic modelReset();
        mExRd  = '0;
        mExWb  = 1'b0;
        mExMr  = 1'b0;
        mWbRd  = '0;
        mWbWb  = 1'b0;
        mState = 1'b0;
        expQ.delete();
    endtask

    task automatic applyStimulus(input logic [4:0] rd, input logic wb, input logic mr,
                                 input logic mw, input logic ack);
        idExRd = rd;
        idExWb = wb;
        idExMr = mr;
        idExMw = mw;
        memAck = ack;
        #1;
    endtask

    // Advances the model by one edge, queues what the DUT should show, then steps past the edge.
    task automatic clockEdge();
        if (mState && !memAck) begin
            mWbRd = '0;
            mWbWb = 1'b0;
        end else begin
            mWbRd  = mExRd;
            mWbWb  = mExWb;
            mExRd  = idExRd;
            mExWb  = idExWb;
            mExMr  = idExMr;
            mState = idExMr | idExMw;
        end
        expQ.push_back({mExRd, mExWb, mExMr, mWbRd, mWbWb, mState});
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        rstN = 1'b0;
        modelReset();
        #2;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        modelReset();
        #3;
        checks++;
        if (obsVec() !== 14'h0 || memStall !== 1'b0 || loadUse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h/%b/%b expected 0000/0/0", obsVec(), memStall, loadUse);
        end
        rstN = 1'b1;
    endtask

    task automatic test_alu();
        applyStimulus(5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        clockEdge();
        expVal = expQ.pop_front();
        checks++;
        if (obsVec() !== expVal || exMemRd !== 5'd8 || exMemWb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_exmem: got %h expected %h", obsVec(), expVal);
        end
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge();
        expVal = expQ.pop_front();
        checks++;
        if (obsVec() !== expVal || memWbRd !== 5'd8 || memWbWb !== 1'b1 || memReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_memwb: got %h expected %h", obsVec(), expVal);
        end
    endtask

    task automatic test_load_use();
        logic [4:0] tRd[5] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd5};
        logic       tMr[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0] tRs[5] = '{5'd5, 5'd3, 5'd0, 5'd1, 5'd5};
        logic [4:0] tRt[5] = '{5'd0, 5'd7, 5'd0, 5'd5, 5'd5};
        logic       tExp[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            ifIdRs = tRs[i];
            ifIdRt = tRt[i];
            applyStimulus(tRd[i], 1'b1, tMr[i], 1'b0, 1'b0);
            checks++;
            if (loadUse !== tExp[i]) begin
                errors++;
                $display("[TB] FAIL load_use_%0d: got %b expected %b", i, loadUse, tExp[i]);
            end
        end
        ifIdRs = '0;
        ifIdRt = '0;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge();
        expVal = expQ.pop_front();
    endtask

    task automatic test_mem_wait();
        int reqCycles = 0;
        int stallCycles = 0;
        applyStimulus(5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        clockEdge();
        expVal = expQ.pop_front();
        checks++;
        if (obsVec() !== expVal) begin
            errors++;
            $display("[TB] FAIL load_capture: got %h expected %h", obsVec(), expVal);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, (i == 3));
            if (memReq) reqCycles++;
            if (memStall) stallCycles++;
            clockEdge();
            expVal = expQ.pop_front();
            checks++;
            if (obsVec() !== expVal || (i < 3 && (exMemRd !== 5'd9 || memWbWb !== 1'b0))) begin
                errors++;
                $display("[TB] FAIL wait_cycle_%0d: got %h expected %h", i, obsVec(), expVal);
            end
        end
        checks++;
        if (reqCycles != 4 || stallCycles != 3) begin
            errors++;
            $display("[TB] FAIL wait_counts: got req=%0d stall=%0d expected req=4 stall=3", reqCycles, stallCycles);
        end
        checks++;
        if (memWbRd !== 5'd9 || memWbWb !== 1'b1 || memReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_retire: got rd=%0d wb=%b req=%b expected rd=9 wb=1 req=0", memWbRd, memWbWb, memReq);
        end
    endtask

    task automatic test_back_to_back();
        int stallSeen = 0;
        int reqDrops = 0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(5'(i), 1'b0, 1'b0, 1'b1, 1'b1);
            if (memStall) stallSeen++;
            clockEdge();
            expVal = expQ.pop_front();
            checks++;
            if (obsVec() !== expVal) begin
                errors++;
                $display("[TB] FAIL b2b_store_%0d: got %h expected %h", i, obsVec(), expVal);
            end
            if (!memReq) reqDrops++;
        end
        checks++;
        if (stallSeen != 0 || reqDrops != 0) begin
            errors++;
            $display("[TB] FAIL b2b_continuous: got stalls=%0d reqDrops=%0d expected 0/0", stallSeen, reqDrops);
        end
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        clockEdge();
        expVal = expQ.pop_front();
        checks++;
        if (obsVec() !== expVal) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %h expected %h", obsVec(), expVal);
        end
    endtask

    task automatic test_reset_mid_access();
        applyStimulus(5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        clockEdge();
        expVal = expQ.pop_front();
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (memReq !== 1'b1 || memStall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre_reset: got req=%b stall=%b expected 1/1", memReq, memStall);
        end
        rstN = 1'b0;
        modelReset();
        #1;
        checks++;
        if (obsVec() !== 14'h0 || memStall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got %h/%b expected 0000/0", obsVec(), memStall);
        end
        rstN = 1'b1;
        applyStimulus(5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        clockEdge();
        expVal = expQ.pop_front();
        checks++;
        if (obsVec() !== expVal || memReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_restart_idle: got %h expected %h", obsVec(), expVal);
        end
    endtask

`ifdef WB_DEST_PIPE_STALL_CNT_EN
    task automatic test_stall_counter();
        int diffs = 0;
        resetPulse();
        applyStimulus(5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        clockEdge();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            clockEdge();
        end
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        clockEdge();
        ifIdRs = 5'd4;
        applyStimulus(5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        clockEdge();
        ifIdRs = '0;
        checks++;
        if (stallCnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL stall_cnt_four: got %0d expected 4", stallCnt);
        end
        expQ.delete();
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            clockEdge();
            expVal = expQ.pop_front();
            if (obsVec() !== expVal) diffs++;
        end
        checks++;
        if (stallCnt !== 16'hFFFF || diffs != 0) begin
            errors++;
            $display("[TB] FAIL stall_cnt_saturate: got %h diffs=%0d expected ffff diffs=0", stallCnt, diffs);
        end
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        clockEdge();
        expVal = expQ.pop_front();
    endtask
`endif

    initial begin
        $display("[TB] wb_dest_pipe bench starting");
        test_reset();
        test_alu();
        test_load_use();
        test_mem_wait();
        test_back_to_back();
        test_reset_mid_access();
`ifdef WB_DEST_PIPE_STALL_CNT_EN
        test_stall_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
